// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from N_REQ requesters
// into a single UART transmitter through a tx_send / tx_busy handshake.
// Optional build macro UART_TX_ARB_WDOG_EN adds a send watchdog. When the
// watchdog fires, it sets the sticky err flag and drops the pending byte.
// Without the macro, err is tied low and no watchdog counter is built.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WDOG_CYC = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         data_in,
  output logic [N_REQ-1:0]           ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_send,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       active,
  output logic                       err
);

  localparam int IW = $clog2(N_REQ);

  // Reject configurations the arbiter was never meant to support.
  if (N_REQ < 2 || N_REQ > 8 || WDOG_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and WDOG_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;

`ifdef UART_TX_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0]   wdog_cnt;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Round-robin pick: scan from ptr+1 upward, wrapping, and take the first pending requester.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Arbiter FSM with registered handshake outputs; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state    <= IDLE;
      ptr      <= IW'(N_REQ - 1);
      ack      <= '0;
      tx_data  <= 8'h00;
      tx_send  <= 1'b0;
      grant_id <= '0;
      active   <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req && !tx_busy) begin
            tx_data     <= data_in[{winner, 3'b000} +: 8];
            grant_id    <= winner;
            ptr         <= winner;
            ack[winner] <= 1'b1;
            tx_send     <= 1'b1;
            active      <= 1'b1;
            state       <= SEND;
`ifdef UART_TX_ARB_WDOG_EN
            wdog_cnt    <= '0;
`endif
          end
        end
        SEND: begin
          if (tx_busy) begin
            tx_send <= 1'b0;
            state   <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_WDOG_EN
          else if (wdog_cnt == CW'(WDOG_CYC - 1)) begin
            tx_send <= 1'b0;
            err_q   <= 1'b1;
            active  <= 1'b0;
            state   <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + CW'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          tx_send <= 1'b0;
          active  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
